uart_frame_decoder: RTL and testbench

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_pkg.sv | 24 ++
 rtl/uart_frame_decoder_if.sv | 30 +++
 rtl/uart_rx_timeout.sv | 39 +++
 rtl/uart_frame_decoder.sv | 145 ++++++++++++++
 tb/tb_uart_frame_decoder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame decoder.
// Holds the decoder FSM state encoding, the err_code values reported on a
// rejected frame, and the default header/trailer byte values.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HDR1 = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_CHK       = 3'd4,
    ST_WAIT_TAIL = 3'd5
  } state_e;

  localparam logic [1:0] ERR_BAD_CHK  = 2'd0;
  localparam logic [1:0] ERR_BAD_TAIL = 2'd1;
  localparam logic [1:0] ERR_BAD_ADDR = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] DEF_HDR0 = 8'h55;
  localparam logic [7:0] DEF_HDR1 = 8'hA5;
  localparam logic [7:0] DEF_TAIL = 8'hF0;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Bundle between a UART byte source and the frame decoder.
//   rx_data/rx_done : byte stream into the decoder
//   ctrl/ctrl_upd   : channel registers and per-channel write pulses
//   frame_err/err_code : reject pulse and its held cause
//   state           : decoder FSM state, debug observation only
// Handshake: rx_done is a one-cycle valid strobe qualifying rx_data; there is
// no ready/backpressure, so the decoder consumes every byte on the cycle it is
// strobed.
interface uart_frame_decoder_if #(
  parameter int N_CH       = 4,
  parameter int DATA_BYTES = 1
);
  logic [7:0]                   rx_data;
  logic                         rx_done;
  logic [N_CH*8*DATA_BYTES-1:0] ctrl;
  logic [N_CH-1:0]              ctrl_upd;
  logic                         frame_err;
  logic [1:0]                   err_code;
  uart_frame_pkg::state_e       state;

  modport master (
    output rx_data, rx_done,
    input  ctrl, ctrl_upd, frame_err, err_code, state
  );

  modport slave (
    input  rx_data, rx_done,
    output ctrl, ctrl_upd, frame_err, err_code, state
  );
endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte idle counter.
//   clear_i   : restart counting (a byte arrived)
//   enable_i  : count while a frame is in progress
//   expired_o : one-cycle pulse on the TIMEOUT_CYC-th consecutive idle clock
// A clear on the terminal cycle suppresses the pulse, so a byte arriving
// exactly at the limit still belongs to the frame.
module uart_rx_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i || expired_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes framed UART bytes (HDR0 HDR1 ADDR payload CHK TAIL) into per-channel
// control registers.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of uart_frame_decoder_if (byte stream in,
//                ctrl/ctrl_upd/frame_err/err_code/state out)
// A frame is always consumed through its trailer byte; the verdict (accept or
// one error cause) is taken on the trailer edge.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         N_CH        = 4,
  parameter int         DATA_BYTES  = 1,
  parameter logic [7:0] HDR0        = DEF_HDR0,
  parameter logic [7:0] HDR1        = DEF_HDR1,
  parameter logic [7:0] TAIL        = DEF_TAIL,
  parameter int         TIMEOUT_CYC = 100000
) (
  input logic               clk,
  input logic               rst_n,
  uart_frame_decoder_if.slave bus
);
  localparam int         DW        = 8 * DATA_BYTES;
  localparam int         CW        = N_CH * DW;
  localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

  state_e          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [DW-1:0]   payload_q, payload_d;
  logic [7:0]      sum_q, sum_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic            chk_ok_q, chk_ok_d;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [N_CH-1:0] ctrl_upd_q, ctrl_upd_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            expired;

  uart_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (bus.rx_done),
    .enable_i (state_q != ST_IDLE),
    .expired_o(expired)
  );

  assign bus.ctrl      = ctrl_q;
  assign bus.ctrl_upd  = ctrl_upd_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.state     = state_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    payload_d   = payload_q;
    sum_d       = sum_q;
    byte_cnt_d  = byte_cnt_q;
    chk_ok_d    = chk_ok_q;
    ctrl_d      = ctrl_q;
    ctrl_upd_d  = '0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    // expired is already masked by rx_done inside the counter.
    if (expired) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end else if (bus.rx_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == HDR0) state_d = ST_WAIT_HDR1;
        end
        ST_WAIT_HDR1: begin
          if (bus.rx_data == HDR1)      state_d = ST_ADDR;
          else if (bus.rx_data != HDR0) state_d = ST_IDLE;
        end
        ST_ADDR: begin
          addr_d     = bus.rx_data;
          sum_d      = bus.rx_data;
          byte_cnt_d = '0;
          state_d    = ST_DATA;
        end
        ST_DATA: begin
          // MS byte arrives first, so shift up and append.
          payload_d  = (payload_q << 8) | DW'(bus.rx_data);
          sum_d      = sum_q + bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_BYTE) state_d = ST_CHK;
        end
        ST_CHK: begin
          chk_ok_d = (bus.rx_data == sum_q);
          state_d  = ST_WAIT_TAIL;
        end
        ST_WAIT_TAIL: begin
          state_d = ST_IDLE;
          if (!chk_ok_q) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_CHK;
          end else if (bus.rx_data != TAIL) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_TAIL;
          end else if (addr_q >= 8'(N_CH)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_ADDR;
          end else begin
            for (int k = 0; k < N_CH; k++) begin
              if (addr_q == 8'(k)) begin
                ctrl_d[k*DW +: DW] = payload_q;
                ctrl_upd_d[k]      = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      payload_q   <= '0;
      sum_q       <= '0;
      byte_cnt_q  <= '0;
      chk_ok_q    <= 1'b0;
      ctrl_q      <= '0;
      ctrl_upd_q  <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      payload_q   <= payload_d;
      sum_q       <= sum_d;
      byte_cnt_q  <= byte_cnt_d;
      chk_ok_q    <= chk_ok_d;
      ctrl_q      <= ctrl_d;
      ctrl_upd_q  <= ctrl_upd_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder. Two instances share one clock:
//   A: N_CH=4, DATA_BYTES=1, TIMEOUT_CYC=50
//   B: N_CH=2, DATA_BYTES=2, default timeout
// Expected output events {frame_err, err_code, ctrl_upd, ctrl} are pushed
// before each frame; per-instance monitors pop and compare whenever the DUT
// raises frame_err or any ctrl_upd bit.
module tb_uart_frame_decoder;
  import uart_frame_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n;

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_a_q[$];
  logic [36:0] exp_b_q[$];

  uart_frame_decoder_if #(.N_CH(4), .DATA_BYTES(1)) a_if ();
  uart_frame_decoder_if #(.N_CH(2), .DATA_BYTES(2)) b_if ();

  uart_frame_decoder #(.N_CH(4), .DATA_BYTES(1), .TIMEOUT_CYC(50)) dut_a (
    .clk  (clk),
    .rst_n(rst_a_n),
    .bus  (a_if)
  );

  uart_frame_decoder #(.N_CH(2), .DATA_BYTES(2)) dut_b (
    .clk  (clk),
    .rst_n(rst_b_n),
    .bus  (b_if)
  );

  // ---------------- driver tasks ----------------
  // Sends the n low bytes of v, most significant first, on consecutive cycles.
  task automatic send_vec(input bit to_b, input logic [63:0] v, input int n);
    logic [7:0] b;
    for (int i = n - 1; i >= 0; i--) begin
      b = v[i*8 +: 8];
      if (to_b) begin
        b_if.rx_data = b;
        b_if.rx_done = 1'b1;
      end else begin
        a_if.rx_data = b;
        a_if.rx_done = 1'b1;
      end
      @(posedge clk);
      #1;
      a_if.rx_done = 1'b0;
      b_if.rx_done = 1'b0;
    end
  endtask

  task automatic push_a(input logic err, input logic [1:0] code,
                        input logic [3:0] upd, input logic [31:0] ctrl);
    exp_a_q.push_back({err, code, upd, ctrl});
  endtask

  task automatic push_b(input logic err, input logic [1:0] code,
                        input logic [1:0] upd, input logic [31:0] ctrl);
    exp_b_q.push_back({err, code, upd, ctrl});
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [38:0] got, e;
    if (rst_a_n && (a_if.frame_err || a_if.ctrl_upd != '0)) begin
      got = {a_if.frame_err, a_if.err_code, a_if.ctrl_upd, a_if.ctrl};
      checks++;
      if (exp_a_q.size() == 0) begin
        failures++;
        $display("FAIL mon_a unexpected event got=%h", got);
      end else begin
        e = exp_a_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL mon_a event got=%h exp=%h (err,code,upd,ctrl)", got, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [36:0] got, e;
    if (rst_b_n && (b_if.frame_err || b_if.ctrl_upd != '0)) begin
      got = {b_if.frame_err, b_if.err_code, b_if.ctrl_upd, b_if.ctrl};
      checks++;
      if (exp_b_q.size() == 0) begin
        failures++;
        $display("FAIL mon_b unexpected event got=%h", got);
      end else begin
        e = exp_b_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL mon_b event got=%h exp=%h (err,code,upd,ctrl)", got, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    a_if.rx_data = '0; a_if.rx_done = 1'b0;
    b_if.rx_data = '0; b_if.rx_done = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);
    check("a_rst_ctrl",      64'(a_if.ctrl),      64'h0);
    check("a_rst_upd",       64'(a_if.ctrl_upd),  64'h0);
    check("a_rst_frame_err", 64'(a_if.frame_err), 64'h0);
    check("a_rst_err_code",  64'(a_if.err_code),  64'h0);
    check("a_rst_state",     64'(a_if.state),     64'(ST_IDLE));
    check("b_rst_ctrl",      64'(b_if.ctrl),      64'h0);
    check("b_rst_state",     64'(b_if.state),     64'(ST_IDLE));
    @(posedge clk);
    #1;

    // ---- instance A ----
    push_a(1'b0, 2'd0, 4'b0100, 32'h003C_0000);          // ch2 = 3C
    send_vec(1'b0, 64'h55A5_023C_3EF0, 6);
    push_a(1'b1, 2'd0, 4'b0000, 32'h003C_0000);          // 01+10 != 12
    send_vec(1'b0, 64'h55A5_0110_12F0, 6);
    push_a(1'b0, 2'd0, 4'b0001, 32'h003C_00AA);          // resync, ch0 = AA
    send_vec(1'b0, 64'h5555_A500_AAAA_F0, 7);
    push_a(1'b1, 2'd2, 4'b0000, 32'h003C_00AA);          // addr 7 out of range
    send_vec(1'b0, 64'h55A5_0701_08F0, 6);
    push_a(1'b1, 2'd1, 4'b0000, 32'h003C_00AA);          // bad trailer
    send_vec(1'b0, 64'h55A5_0311_14EE, 6);
    push_a(1'b1, 2'd0, 4'b0000, 32'h003C_00AA);          // all three causes: checksum wins
    send_vec(1'b0, 64'h55A5_0900_0000, 6);
    // Back-to-back frames with HDR0 / TAIL values as payload.
    push_a(1'b0, 2'd0, 4'b1000, 32'h553C_00AA);
    push_a(1'b0, 2'd0, 4'b0010, 32'h553C_F0AA);
    send_vec(1'b0, 64'h55A5_0355_58F0, 6);
    send_vec(1'b0, 64'h55A5_01F0_F1F0, 6);
    // Noise in IDLE and a failed HDR1 are ignored silently.
    send_vec(1'b0, 64'h1234_5500, 4);
    push_a(1'b0, 2'd0, 4'b0100, 32'h5577_F0AA);
    send_vec(1'b0, 64'h55A5_0277_79F0, 6);
    // Byte arriving exactly on the timeout terminal cycle keeps the frame.
    push_a(1'b0, 2'd0, 4'b0010, 32'h5577_3CAA);
    send_vec(1'b0, 64'h55A5_01, 3);
    repeat (49) @(posedge clk);
    #1;
    send_vec(1'b0, 64'h3C3D_F0, 3);
    // Real timeout: 50 idle clocks after ADDR.
    push_a(1'b1, 2'd3, 4'b0000, 32'h5577_3CAA);
    send_vec(1'b0, 64'h55A5_01, 3);
    repeat (49) @(posedge clk);
    #1;
    check("a_to_no_early_err", 64'(a_if.frame_err), 64'h0);
    check("a_to_state_data",   64'(a_if.state),     64'(ST_DATA));
    @(posedge clk);
    #1;
    check("a_to_err_pulse", 64'(a_if.frame_err), 64'h1);
    check("a_to_err_code",  64'(a_if.err_code),  64'h3);
    check("a_to_state_idle", 64'(a_if.state),    64'(ST_IDLE));
    repeat (3) @(posedge clk);
    #1;
    push_a(1'b0, 2'd3, 4'b0001, 32'h5577_3C01);          // err_code held at 3
    send_vec(1'b0, 64'h55A5_0001_01F0, 6);

    // ---- instance B ----
    push_b(1'b0, 2'd0, 2'b10, 32'h1234_0000);            // ch1 = 1234
    send_vec(1'b1, 64'h55A5_0112_3447_F0, 7);
    push_b(1'b1, 2'd2, 2'b00, 32'h1234_0000);            // addr 2 with N_CH=2
    send_vec(1'b1, 64'h55A5_0200_0103_F0, 7);
    send_vec(1'b1, 64'h55A5, 2);
    #1;
    rst_b_n = 1'b0;
    #1;
    check("b_mid_rst_ctrl",      64'(b_if.ctrl),      64'h0);
    check("b_mid_rst_err_code",  64'(b_if.err_code),  64'h0);
    check("b_mid_rst_frame_err", 64'(b_if.frame_err), 64'h0);
    check("b_mid_rst_upd",       64'(b_if.ctrl_upd),  64'h0);
    check("b_mid_rst_state",     64'(b_if.state),     64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;
    push_b(1'b0, 2'd0, 2'b01, 32'h0000_ABCD);            // 00+AB+CD = 178 -> 78
    send_vec(1'b1, 64'h55A5_00AB_CD78_F0, 7);

    repeat (5) @(posedge clk);
    #1;
    check("a_queue_drained", 64'(exp_a_q.size()), 64'h0);
    check("b_queue_drained", 64'(exp_b_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
